pk_gen_scheduler: RTL

PK_GEN_SCHEDULER -- requirements
Module: pk_gen_scheduler

---
 rtl/pk_sched_pkg.sv | 22 ++
 rtl/pk_gen_scheduler_if.sv | 12 +
 rtl/pk_rr_arbiter.sv | 31 +++
 rtl/pk_gen_scheduler.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pk_sched_pkg.sv
// Shared types and constants for the public-key generation scheduler.
// Holds only values common to the scheduler, its arbiter and its engine partner.
package pk_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } pks_state_e;

  localparam int         P_MOD  = 227;
  localparam int         Q_OFF  = 225;
  localparam logic [7:0] SK_MIN = 8'd1;
  localparam logic [7:0] SK_MAX = 8'd226;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_GEN  = 2'b01;

  localparam logic [7:0] NULL_CHAR = 8'h00;

endpackage

// File: rtl/pk_gen_scheduler_if.sv
// Link between the scheduler and the shared public-key engine.
// master = scheduler side, slave = engine side.
interface pk_gen_scheduler_if;
  logic [1:0] eng_mode;
  logic [7:0] eng_sk;
  logic [7:0] eng_pk;
  logic       eng_ready;
  logic       eng_err;

  modport master (output eng_mode, eng_sk, input eng_pk, eng_ready, eng_err);
  modport slave  (input eng_mode, eng_sk, output eng_pk, eng_ready, eng_err);
endinterface

// File: rtl/pk_rr_arbiter.sv
// Rotating-priority picker: first active request at or after ptr wins.
// Purely combinational; the owner advances ptr after each completed service.
module pk_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             hit
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = IW'((int'(ptr) + k) % N_REQ);
      if (!hit && req[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
    gnt[idx] = hit;
  end

endmodule

// File: rtl/pk_gen_scheduler.sv
// Round-robin scheduler sharing one public-key engine among N_REQ requesters.
// Optional PKS_PRECHECK_EN: range-check keys locally and bypass the engine for bad ones.
module pk_gen_scheduler
  import pk_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 8,
  parameter int IW          = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   sk_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [7:0]           pk_out,
  output logic [IW-1:0]        pk_id,
  output logic                 pk_valid,
  output logic                 err_invalid,
  output logic                 err_timeout,
  output logic                 busy,
  pk_gen_scheduler_if.master   eng
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  pks_state_e     state, state_nxt;
  logic [IW-1:0]  ptr, id_r;
  logic [7:0]     sk_r, pk_r, cnt;
  logic           skip_r, err_inv_r, err_to_r;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_hit;
  logic [7:0]       sk_sel;
  logic             sk_bad;

  pk_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .hit (arb_hit)
  );

  assign sk_sel = sk_in[{arb_idx, 3'b000} +: 8];

`ifdef PKS_PRECHECK_EN
  assign sk_bad = (sk_sel < SK_MIN) || (sk_sel > SK_MAX);
`else
  assign sk_bad = 1'b0;
`endif

  // Outputs are decoded from the registered state so they are glitch-free
  // and drop to idle values the cycle after a reset.
  always_comb begin
    state_nxt    = state;
    gnt          = '0;
    pk_valid     = 1'b0;
    pk_out       = NULL_CHAR;
    pk_id        = '0;
    err_invalid  = 1'b0;
    err_timeout  = 1'b0;
    busy         = (state != S_IDLE);
    eng.eng_mode = MODE_IDLE;
    eng.eng_sk   = NULL_CHAR;
    case (state)
      S_IDLE: if (arb_hit) state_nxt = S_ISSUE;
      S_ISSUE: begin
        gnt[id_r] = 1'b1;
        if (skip_r) state_nxt = S_RESP;
        else begin
          eng.eng_mode = MODE_GEN;
          eng.eng_sk   = sk_r;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        eng.eng_mode = MODE_GEN;
        eng.eng_sk   = sk_r;
        if (eng.eng_ready || eng.eng_err || cnt == CNT_LAST) state_nxt = S_RESP;
      end
      S_RESP: begin
        pk_valid    = 1'b1;
        pk_out      = pk_r;
        pk_id       = id_r;
        err_invalid = err_inv_r;
        err_timeout = err_to_r;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id_r      <= '0;
      sk_r      <= '0;
      pk_r      <= '0;
      cnt       <= '0;
      skip_r    <= 1'b0;
      err_inv_r <= 1'b0;
      err_to_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (arb_hit) begin
          id_r   <= arb_idx;
          sk_r   <= sk_sel;
          skip_r <= sk_bad;
        end
        S_ISSUE: begin
          cnt       <= '0;
          pk_r      <= NULL_CHAR;
          err_inv_r <= skip_r;
          err_to_r  <= 1'b0;
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          // ready wins over err, err wins over the timeout
          if (eng.eng_ready) pk_r <= eng.eng_pk;
          else if (eng.eng_err) err_inv_r <= 1'b1;
          else if (cnt == CNT_LAST) err_to_r <= 1'b1;
        end
        S_RESP: ptr <= (id_r == IW'(N_REQ - 1)) ? '0 : id_r + IW'(1);
        default: ;
      endcase
    end
  end

endmodule
